bs_gnrtr_n_rbtr: RTL and testbench

- Shared-bus generator and arbiter. It connects `drvrs` driver FIFOs over `bits` independent buses.
- Each bus grants its pending drivers in round-robin order. It pops one packet from the granted driver's FIFO and decodes the destination ID from the packet MSBs.
- It then pushes the packet into the addressed driver's input FIFO, or into every other driver on broadcast.
- Sits between the per-driver FIFO pairs of the bus-driver subsystem; the test environment drives it through its complete interface.

---
 rtl/bs_gnrtr_n_rbtr.sv | 126 ++++++++++++
 tb/tb_bs_gnrtr_n_rbtr.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bs_gnrtr_n_rbtr.sv
// Shared-bus generator and arbiter.
// Each of the `bits` buses runs its own round-robin arbiter and a three-state
// FSM (IDLE -> POP -> PUSH). One packet moves from the granted driver's output
// FIFO to the driver(s) addressed by the packet's top byte.
module bs_gnrtr_n_rbtr #(
  parameter int          bits      = 1,
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  output logic [bits-1:0][drvrs-1:0]              pop,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    PUSH
  } state_t;

  for (genvar b = 0; b < bits; b++) begin : g_bus

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gnt;
    logic               found;
    logic [7:0]         id;
    logic [pckg_sz-1:0] pkt;
    logic [drvrs-1:0]   pop_q;
    logic [drvrs-1:0]   push_q;
    logic [drvrs-1:0]   pop_nxt;
    logic [drvrs-1:0]   push_nxt;

    // The granted driver (held in ptr while in POP) supplies the destination ID.
    assign id = D_pop[b][ptr][pckg_sz-1 -: 8];

    // Round-robin search: first pending driver starting just after the last grant.
    always_comb begin
      logic [PW-1:0] idx;
      gnt   = ptr;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= drvrs; k++) begin
        idx = PW'((int'(ptr) + k) % drvrs);
        if (!found && pndng[b][idx]) begin
          gnt   = idx;
          found = 1'b1;
        end
      end
    end

    // State register plus registered strobes, grant pointer and packet latch.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= IDLE;
        ptr    <= PW'(drvrs - 1);
        pop_q  <= '0;
        push_q <= '0;
        pkt    <= '0;
      end else begin
        state  <= state_nxt;
        pop_q  <= pop_nxt;
        push_q <= push_nxt;
        if (state == IDLE && found) begin
          ptr <= gnt;
        end
        if (state == POP) begin
          pkt <= D_pop[b][ptr];
        end
      end
    end

    // Next-state logic: a grant always runs through one POP and one PUSH cycle.
    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (found) state_nxt = POP;
        POP:     state_nxt = PUSH;
        PUSH:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // Output logic: compute the strobes that become visible after the next edge.
    // Unknown IDs never match a driver index, so they are dropped naturally.
    always_comb begin
      pop_nxt  = '0;
      push_nxt = '0;
      case (state)
        IDLE: begin
          if (found) pop_nxt[gnt] = 1'b1;
        end
        POP: begin
          for (int i = 0; i < drvrs; i++) begin
            if (id == broadcast) begin
              push_nxt[i] = (PW'(i) != ptr);
            end else begin
              push_nxt[i] = (id == 8'(i));
            end
          end
        end
        default: begin
          pop_nxt  = '0;
          push_nxt = '0;
        end
      endcase
    end

    assign pop[b]  = pop_q;
    assign push[b] = push_q;

    for (genvar i = 0; i < drvrs; i++) begin : g_dpush
      assign D_push[b][i] = pkt;
    end

  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Self-checking bench for bs_gnrtr_n_rbtr with 8 drivers on one bus.
// Expected strobes are queued when a transfer is launched and compared,
// one entry per cycle, on the falling clock edge.
module tb_bs_gnrtr_n_rbtr;

  localparam int BITS  = 1;
  localparam int DRVRS = 8;
  localparam int PSZ   = 16;

  logic clk = 1'b0;
  logic reset;
  logic [BITS-1:0][DRVRS-1:0]          pndng;
  logic [BITS-1:0][DRVRS-1:0]          pop;
  logic [BITS-1:0][DRVRS-1:0][PSZ-1:0] D_pop;
  logic [BITS-1:0][DRVRS-1:0]          push;
  logic [BITS-1:0][DRVRS-1:0][PSZ-1:0] D_push;

  typedef struct {
    logic [7:0]  pop;
    logic [7:0]  push;
    logic [15:0] data;
    bit          chkData;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  bs_gnrtr_n_rbtr #(
    .bits     (BITS),
    .drvrs    (DRVRS),
    .pckg_sz  (PSZ),
    .broadcast(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pndng (pndng),
    .pop   (pop),
    .D_pop (D_pop),
    .push  (push),
    .D_push(D_push)
  );

  // Destination decode model: broadcast skips the sender, unknown IDs push nothing.
  function automatic logic [7:0] expPush(logic [15:0] pkt, int g);
    logic [7:0] id;
    id = pkt[15:8];
    if (id == 8'hFF) return ~(8'(1) << g);
    else if (id < 8'd8) return 8'(1) << id;
    else return 8'h00;
  endfunction

  task automatic compareVal(string tag, logic [127:0] obs, logic [127:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected at least 1");
      return;
    end
    e = sb.pop_front();
    compareVal({e.tag, "_pop"}, 128'(pop[0]), 128'(e.pop));
    compareVal({e.tag, "_push"}, 128'(push[0]), 128'(e.push));
    if (e.chkData) compareVal({e.tag, "_dpush"}, 128'(D_push[0]), {8{e.data}});
  endtask

  task automatic queueTransfer(int g, logic [15:0] data, string tag);
    sb.push_back('{pop: 8'(1) << g, push: 8'h00, data: 16'h0, chkData: 1'b0, tag: {tag, "_c0"}});
    sb.push_back('{pop: 8'h00, push: expPush(data, g), data: data, chkData: 1'b1, tag: {tag, "_c1"}});
    sb.push_back('{pop: 8'h00, push: 8'h00, data: 16'h0, chkData: 1'b0, tag: {tag, "_c2"}});
  endtask

  // Launch a single transfer from driver g; pending drops during POP on purpose.
  task automatic applyStimulus(int g, logic [15:0] data, string tag);
    pndng[0]    = 8'(1) << g;
    D_pop[0][g] = data;
    queueTransfer(g, data, tag);
    @(negedge clk);
    pndng[0] = '0;
    checkOutput();
    @(negedge clk);
    checkOutput();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rr[6];
    reset = 1'b1;
    pndng = '0;
    D_pop = '0;
    #2;
    reset    = 1'b0;
    pndng[0] = 8'($urandom);
    for (int i = 0; i < DRVRS; i++) D_pop[0][i] = 16'($urandom);
    #1;
    compareVal("rst_pop", 128'(pop[0]), 128'h0);
    compareVal("rst_push", 128'(push[0]), 128'h0);
    compareVal("rst_dpush", 128'(D_push[0]), 128'h0);
    repeat (3) @(negedge clk);
    compareVal("rst_hold_pop", 128'(pop[0]), 128'h0);
    compareVal("rst_hold_push", 128'(push[0]), 128'h0);

    pndng = '0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compareVal("idle_pop", 128'(pop[0]), 128'h0);
      compareVal("idle_push", 128'(push[0]), 128'h0);
      compareVal("idle_dpush", 128'(D_push[0]), 128'h0);
    end

    applyStimulus(2, 16'h05AB, "single");
    applyStimulus(3, 16'hFF12, "bcast");
    applyStimulus(1, 16'h0A00, "badid");
    applyStimulus(6, 16'h0601, "self");

    pndng[0]    = 8'h10;
    D_pop[0][4] = 16'h0312;
    @(negedge clk);
    compareVal("rstpop_pop", 128'(pop[0]), 128'h10);
    reset = 1'b0;
    #1;
    compareVal("rstpop_async_pop", 128'(pop[0]), 128'h0);
    compareVal("rstpop_async_push", 128'(push[0]), 128'h0);
    compareVal("rstpop_async_dpush", 128'(D_push[0]), 128'h0);
    @(negedge clk);
    compareVal("rstpop_nopush", 128'(push[0]), 128'h0);
    compareVal("rstpop_nopop", 128'(pop[0]), 128'h0);

    D_pop[0][0] = 16'h0100;
    D_pop[0][1] = 16'hFF55;
    D_pop[0][7] = 16'h0077;
    pndng[0]    = 8'h83;
    rr = '{0, 1, 7, 0, 1, 7};
    foreach (rr[j]) queueTransfer(rr[j], D_pop[0][rr[j]], $sformatf("rr%0d", j));
    reset = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      checkOutput();
    end
    pndng = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
